// File: rtl/gx4000_asic_ram_arbiter_pkg.sv
// Shared types and constants for the GX4000 Plus ASIC RAM arbiter.
package gx4000_asic_pkg;

    localparam int unsigned ASIC_AW     = 14;
    localparam logic [7:0]  LOCKED_DATA = 8'hFF;

    // Owner of a RAM slot; also the tag carried down the read pipeline.
    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_VID,
        OWN_SPR,
        OWN_CPU
    } owner_t;

endpackage

// File: rtl/gx4000_asic_ram_arbiter_if.sv
// Requester and RAM-side signal bundle for the ASIC RAM arbiter.
// The arbiter uses the slave modport; requesters and the RAM macro use master.
interface gx4000_asic_ram_arbiter_if;
    import gx4000_asic_pkg::*;

    logic               asic_unlocked;
    logic               vid_req;
    logic [ASIC_AW-1:0] vid_addr;
    logic               vid_rvalid;
    logic               spr_req;
    logic [ASIC_AW-1:0] spr_addr;
    logic               spr_ack;
    logic               spr_rvalid;
    logic               cpu_req;
    logic               cpu_we;
    logic [ASIC_AW-1:0] cpu_addr;
    logic [7:0]         cpu_wdata;
    logic               cpu_ack;
    logic               cpu_rvalid;
    logic [7:0]         rd_data;
    logic [ASIC_AW-1:0] ram_addr;
    logic               ram_rd;
    logic               ram_wr;
    logic [7:0]         ram_din;
    logic [7:0]         ram_q;

    modport slave (
        input  asic_unlocked, vid_req, vid_addr, spr_req, spr_addr,
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_q,
        output vid_rvalid, spr_ack, spr_rvalid, cpu_ack, cpu_rvalid, rd_data,
        output ram_addr, ram_rd, ram_wr, ram_din
    );

    modport master (
        output asic_unlocked, vid_req, vid_addr, spr_req, spr_addr,
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_q,
        input  vid_rvalid, spr_ack, spr_rvalid, cpu_ack, cpu_rvalid, rd_data,
        input  ram_addr, ram_rd, ram_wr, ram_din
    );

endinterface

// File: rtl/gx4000_asic_ram_arbiter_prio.sv
// Combinational grant selector: video > sprite > CPU, with the CPU masked
// while its ack is showing. A starved CPU (GX4000_ARB_STARVE_EN builds only)
// jumps ahead of the sprite but never ahead of video.
module gx4000_asic_ram_prio
    import gx4000_asic_pkg::*;
(
    input  logic   vid_req,
    input  logic   spr_req,
    input  logic   cpu_req,
    input  logic   cpu_mask,
    input  logic   starved,
    output owner_t grant
);

    logic cpu_pend;

    assign cpu_pend = cpu_req & ~cpu_mask;

    // Pick at most one owner for this cycle's slot
    always_comb begin
        grant = OWN_NONE;
        if (vid_req) begin
            grant = OWN_VID;
        end else if (cpu_pend && starved) begin
            grant = OWN_CPU;
        end else if (spr_req) begin
            grant = OWN_SPR;
        end else if (cpu_pend) begin
            grant = OWN_CPU;
        end
    end

endmodule

// File: rtl/gx4000_asic_ram_arbiter.sv
// GX4000 Plus ASIC RAM arbiter top: registered RAM controls, acks and a
// 3-stage owner-tag/read-data pipeline (fixed 3-cycle read latency).
// Optional macro GX4000_ARB_STARVE_EN builds the CPU anti-starvation counter.
module gx4000_asic_ram_arbiter
    import gx4000_asic_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 8
) (
    input logic                      clk_sys,
    input logic                      reset_n,
    gx4000_asic_ram_arbiter_if.slave bus
);

    if ((STARVE_LIMIT < 2) || (STARVE_LIMIT > 15)) begin : g_bad_limit
        $error("STARVE_LIMIT must be in 2..15");
    end

    owner_t             grant;
    logic               starved;

    logic [ASIC_AW-1:0] ram_addr;
    logic               ram_rd;
    logic               ram_wr;
    logic [7:0]         ram_din;
    logic               spr_ack;
    logic               cpu_ack;
    owner_t             tag1;
    logic               lock1;
    owner_t             tag2;
    logic               lock2;
    logic [7:0]         rd_data;
    logic               vid_rvalid;
    logic               spr_rvalid;
    logic               cpu_rvalid;

    gx4000_asic_ram_prio u_prio (
        .vid_req  (bus.vid_req),
        .spr_req  (bus.spr_req),
        .cpu_req  (bus.cpu_req),
        .cpu_mask (cpu_ack),
        .starved  (starved),
        .grant    (grant)
    );

`ifdef GX4000_ARB_STARVE_EN
    logic [3:0] age;
    logic       cpu_lost;

    // A live CPU request that lost this slot to the sprite
    assign cpu_lost = bus.cpu_req & ~cpu_ack & (grant == OWN_SPR);

    // Age the CPU request on each sprite win; cleared once the CPU is acked
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            age <= 4'd0;
        end else if (cpu_ack) begin
            age <= 4'd0;
        end else if (cpu_lost && (age != 4'hF)) begin
            age <= 4'(age + 4'd1);
        end
    end

    assign starved = (age >= 4'(STARVE_LIMIT));
`else
    assign starved = 1'b0;
`endif

    // Register the granted access onto the RAM port and raise the matching ack
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            ram_addr <= '0;
            ram_rd   <= 1'b0;
            ram_wr   <= 1'b0;
            ram_din  <= 8'h00;
            spr_ack  <= 1'b0;
            cpu_ack  <= 1'b0;
            tag1     <= OWN_NONE;
            lock1    <= 1'b0;
        end else begin
            ram_rd  <= 1'b0;
            ram_wr  <= 1'b0;
            spr_ack <= 1'b0;
            cpu_ack <= 1'b0;
            tag1    <= OWN_NONE;
            lock1   <= 1'b0;
            case (grant)
                OWN_VID: begin
                    ram_rd   <= 1'b1;
                    ram_addr <= bus.vid_addr;
                    tag1     <= OWN_VID;
                end
                OWN_SPR: begin
                    ram_rd   <= 1'b1;
                    ram_addr <= bus.spr_addr;
                    spr_ack  <= 1'b1;
                    tag1     <= OWN_SPR;
                end
                OWN_CPU: begin
                    cpu_ack <= 1'b1;
                    // Locked page: ack and answer reads, but keep the RAM untouched
                    if (bus.asic_unlocked) begin
                        ram_addr <= bus.cpu_addr;
                        if (bus.cpu_we) begin
                            ram_wr  <= 1'b1;
                            ram_din <= bus.cpu_wdata;
                        end else begin
                            ram_rd <= 1'b1;
                        end
                    end
                    if (!bus.cpu_we) begin
                        tag1  <= OWN_CPU;
                        lock1 <= ~bus.asic_unlocked;
                    end
                end
                default: ;
            endcase
        end
    end

    // Delay the tag one cycle so it lines up with ram_q
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            tag2  <= OWN_NONE;
            lock2 <= 1'b0;
        end else begin
            tag2  <= tag1;
            lock2 <= lock1;
        end
    end

    // Capture read data and steer the single rvalid for its owner
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            rd_data    <= 8'h00;
            vid_rvalid <= 1'b0;
            spr_rvalid <= 1'b0;
            cpu_rvalid <= 1'b0;
        end else begin
            vid_rvalid <= (tag2 == OWN_VID);
            spr_rvalid <= (tag2 == OWN_SPR);
            cpu_rvalid <= (tag2 == OWN_CPU);
            if (tag2 != OWN_NONE) begin
                rd_data <= lock2 ? LOCKED_DATA : bus.ram_q;
            end
        end
    end

    assign bus.ram_addr   = ram_addr;
    assign bus.ram_rd     = ram_rd;
    assign bus.ram_wr     = ram_wr;
    assign bus.ram_din    = ram_din;
    assign bus.spr_ack    = spr_ack;
    assign bus.cpu_ack    = cpu_ack;
    assign bus.rd_data    = rd_data;
    assign bus.vid_rvalid = vid_rvalid;
    assign bus.spr_rvalid = spr_rvalid;
    assign bus.cpu_rvalid = cpu_rvalid;

endmodule

// File: doc/gx4000_asic_ram_arbiter.md
# gx4000_asic_ram_arbiter

Arbitrates the single-port 16 KB Plus ASIC RAM between three requesters: video/palette fetch, sprite pixel fetch and CPU register-page access. It sits between the GX4000 video path (palette and sprite engines) and the ASIC RAM macro. Video slots are real-time and always win. Sprite and CPU share the remaining slots under fixed priority, with an optional CPU anti-starvation guard. Every access uses registered RAM controls and has a fixed read latency.

## Interface
- STARVE_LIMIT, 8: cycles a pending CPU request may lose to sprite before it is forced through (guard build only); legal 2..15.
- clk_sys  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- asic_unlocked  in  1  ASIC register page mapped; 0 = CPU accesses must not touch RAM
- vid_req  in  1  single-cycle video read strobe
- vid_addr  in  14  video read address
- vid_rvalid  out  1  video read data valid on rd_data
- spr_req  in  1  sprite read request, level; may be held for bursts
- spr_addr  in  14  sprite address; advance after each spr_ack
- spr_ack  out  1  sprite request accepted
- spr_rvalid  out  1  sprite read data valid
- cpu_req  in  1  CPU request, level, held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  14  CPU address
- cpu_wdata  in  8  CPU write data
- cpu_ack  out  1  CPU request accepted
- cpu_rvalid  out  1  CPU read data valid
- rd_data  out  8  shared read-return data
- ram_addr  out  14  RAM address
- ram_rd  out  1  RAM read enable
- ram_wr  out  1  RAM write enable
- ram_din  out  8  RAM write data
- ram_q  in  8  RAM read data, valid the cycle after ram_rd

## Operation
- Arbitration in cycle N uses that cycle's requests. Priority is video, then sprite, then CPU. At most one grant per cycle.
- Video strobes are never refused or delayed. The video owner has no ack.
- Sprite grant: spr_ack=1 in N+1. The sprite requester may keep spr_req high with a new spr_addr for back-to-back grants.
- CPU grant: cpu_ack=1 in N+1. The CPU requester drops cpu_req in the cycle after it sees ack. While cpu_ack=1, the CPU request is masked from arbitration, so there is no double grant.
- CPU grant while asic_unlocked=1:
  - Write: ram_wr=1 with ram_din=cpu_wdata in N+1.
  - Read: handled like any other read.
- CPU grant while asic_unlocked=0:
  - The request is acked normally, but ram_rd and ram_wr stay 0.
  - A read returns LOCKED_DATA (8'hFF) with normal cpu_rvalid timing.
- Read pipeline, stage by stage:
  - N+1: ram_addr and ram_rd are driven, and a 2-bit owner tag is captured.
  - N+2: ram_q is registered together with the tag.
  - N+3: rd_data is updated and exactly one of the rvalid outputs is asserted for that tag.
- Idle cycles: ram_rd=0, ram_wr=0. ram_addr holds its last value.

## Timing
- Reset values: every output is 0, including rd_data, ram_addr and ram_din. The tag pipeline and the age counter are cleared.
- Read latency from request to rvalid is 3 cycles for every owner, fully pipelined at one read per cycle.
- Write latency from request to ram_wr is 1 cycle. Writes produce no rvalid.
- Simultaneous requests: losers keep their requests pending. There is no queue beyond the held request lines.
- Reset asserted mid-operation: in-flight reads are discarded and no rvalid appears after reset_n rises. The first possible grant is in the cycle after reset_n is sampled high.
- vid_req arriving while the CPU is masked: video is granted as normal. The mask affects the CPU only.

## Configuration
- GX4000_ARB_STARVE_EN defined:
  - A 4-bit age counter increments on each cycle where the CPU has a pending request that is not masked, is not granted, and loses to the sprite.
  - When the count reaches STARVE_LIMIT, the CPU beats the sprite (never video) on the next contest.
  - The counter clears on cpu_ack.
- GX4000_ARB_STARVE_EN undefined:
  - Strict priority applies. A continuous sprite burst blocks the CPU indefinitely.
  - The age counter is not built.

## Structure
- Shared package gx4000_asic_pkg holds:
  - owner_t enum: OWN_NONE, OWN_VID, OWN_SPR, OWN_CPU
  - ASIC_AW = 14
  - LOCKED_DATA = 8'hFF
- One sub-module, gx4000_asic_ram_prio: the combinational grant selector, including the CPU mask and the optional age override. The top level holds the registered RAM controls and the 3-stage tag/data pipeline.

## Test plan
- Reset: hold reset_n=0 with all reqs=1 -> all outputs 0 and no ram_rd. After release, the first ram_rd comes 1 cycle after the first sampled request.
- Video read: vid_req at N, vid_addr=14'h0123, ram_q=8'h5A at N+2 -> ram_rd and ram_addr=14'h0123 at N+1; vid_rvalid=1 and rd_data=8'h5A at N+3.
- Three-way collision: vid, spr and cpu(read) requested at N, with video strobing only at N:
  - Grants go to video at N+1, sprite at N+2, then sprite again for as long as spr_req is held.
  - Drop spr_req at N+1 -> CPU is granted at N+2; its rvalid follows 3 cycles after the grant decision.
- Starvation, sprite held high and cpu write 14'h2400 := 8'h3C:
  - Macro defined -> ram_wr with ram_din=8'h3C within STARVE_LIMIT+2 cycles.
  - Macro undefined -> no ram_wr until spr_req drops.
- Locked access with asic_unlocked=0:
  - CPU read 14'h0000 -> cpu_ack at N+1, ram_rd=0, cpu_rvalid at N+3 with rd_data=8'hFF.
  - CPU write -> no ram_wr.
- Reset mid-read: spr read at N, reset_n=0 at N+2 -> spr_rvalid never asserts; all outputs 0 during reset.
